rr_stream_mux: RTL and testbench

- Parametrised N-channel, WIDTH-bit stream multiplexer. It is the successor to the fixed 2:1 and 4:1 combinational muxes.
- Selection is made by an internal round-robin arbiter, not an external select.
- Each input channel and the output use a valid/ready handshake. The output side has one registered pipeline stage.
- Sits between multiple producer streams and a single shared consumer, e.g. a datapath result bus or a shared memory port.

---
 rtl/rr_stream_mux.sv | 213 +++++++++++++++++++++
 tb/tb_rr_stream_mux.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_stream_mux.sv
// -----------------------------------------------------------------------------
// rr_stream_mux
// N-channel, WIDTH-bit valid/ready stream multiplexer with an internal
// round-robin arbiter and one registered output stage. It replaces the old
// fixed 2:1 / 4:1 combinational muxes in front of a shared consumer.
//
// Parameters
//   WIDTH : data bits per channel
//   N     : number of input channels (N >= 1)
//   SELW  : width of the channel index (derived, leave at default)
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset
//   in_data   in   N*WIDTH, channel i at [i*WIDTH +: WIDTH]
//   in_valid  in   N, per-channel valid
//   in_last   in   N, per-channel end-of-packet marker
//   in_ready  out  N, per-channel ready (combinational)
//   out_data  out  WIDTH, registered data
//   out_last  out  registered end-of-packet marker
//   out_sel   out  SELW, registered index of the source channel
//   out_valid out  registered valid
//   out_ready in   consumer ready
//
// Optional build macro
//   RR_STREAM_MUX_PKT_LOCK_EN : once a channel is granted a beat that is not
//   the last of its packet, the arbiter stays on that channel until the
//   packet's last beat has transferred. Undefined: every beat is arbitrated
//   independently and in_last is pure sideband.
// -----------------------------------------------------------------------------
module rr_stream_mux #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  // Output pipeline stage
  logic [WIDTH-1:0] r_outData;
  logic             r_outLast;
  logic [SELW-1:0]  r_outSel;
  logic             r_outValid;

  // Round-robin pointer: the channel with highest priority this cycle
  logic [SELW-1:0]  r_ptr;

  // Arbitration and datapath nets
  logic             w_loadOk;
  logic             w_searchFound;
  logic [SELW-1:0]  w_searchGrant;
  logic             w_grantFound;
  logic [SELW-1:0]  w_grant;
  logic [WIDTH-1:0] w_grantData;
  logic             w_grantLast;
  logic             w_xfer;
  logic [SELW-1:0]  w_ptrNext;

  // (idx + 1) mod N without a divider; for N == 1 this always yields 0.
  function automatic logic [SELW-1:0] incWrap(input logic [SELW-1:0] idx);
    logic [SELW:0] sum;
    sum = {1'b0, idx} + 1'b1;
    if (sum >= (SELW+1)'(N)) begin
      return '0;
    end
    return sum[SELW-1:0];
  endfunction

  // The output register can take a new beat when it is empty or is being
  // drained in this same cycle, which gives one beat per cycle throughput.
  assign w_loadOk = !r_outValid || out_ready;

  // Round-robin search starting at r_ptr. The loop walks from the farthest
  // candidate back towards r_ptr so the nearest valid channel is the last
  // assignment and therefore wins.
  always_comb begin
    int              sumIdx;
    logic [SELW-1:0] cand;
    w_searchFound = 1'b0;
    w_searchGrant = '0;
    sumIdx        = 0;
    cand          = '0;
    for (int k = N-1; k >= 0; k--) begin
      sumIdx = int'(r_ptr) + k;
      if (sumIdx >= N) begin
        sumIdx = sumIdx - N;
      end
      cand = SELW'(sumIdx);
      if (in_valid[cand]) begin
        w_searchFound = 1'b1;
        w_searchGrant = cand;
      end
    end
  end

`ifdef RR_STREAM_MUX_PKT_LOCK_EN
  // Packet lock state: set by a non-last beat, cleared by the last beat.
  logic            r_lock;
  logic [SELW-1:0] r_lockCh;

  // While locked the search is bypassed and only the locked channel is
  // offered ready, whether or not it is currently valid.
  always_comb begin
    if (r_lock) begin
      w_grantFound = 1'b1;
      w_grant      = r_lockCh;
    end else begin
      w_grantFound = w_searchFound;
      w_grant      = w_searchGrant;
    end
  end

  // Every transferred beat either opens/continues a packet (last == 0) or
  // closes it (last == 1); the channel is recorded on each transfer so the
  // opening beat captures it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lock   <= 1'b0;
      r_lockCh <= '0;
    end else if (w_xfer) begin
      r_lock   <= !w_grantLast;
      r_lockCh <= w_grant;
    end
  end

  // The pointer only moves past a channel once its packet has finished.
  always_comb begin
    w_ptrNext = r_ptr;
    if (w_xfer && w_grantLast) begin
      w_ptrNext = incWrap(w_grant);
    end
  end
`else
  always_comb begin
    w_grantFound = w_searchFound;
    w_grant      = w_searchGrant;
  end

  // Each transferred beat hands priority to the next channel.
  always_comb begin
    w_ptrNext = r_ptr;
    if (w_xfer) begin
      w_ptrNext = incWrap(w_grant);
    end
  end
`endif

  // Only the granted channel sees ready, and never while in reset.
  always_comb begin
    in_ready = '0;
    if (rst_n && w_grantFound) begin
      in_ready[w_grant] = w_loadOk;
    end
  end

  assign w_xfer = |(in_valid & in_ready);

  // Select the granted channel's payload; a compare-per-channel mux avoids
  // a variable-width part select.
  always_comb begin
    w_grantData = '0;
    w_grantLast = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_grant == SELW'(i)) begin
        w_grantData = in_data[i*WIDTH +: WIDTH];
        w_grantLast = in_last[i];
      end
    end
  end

  // Output stage: load on transfer, otherwise drop valid once the consumer
  // has taken the beat. Payload is held whenever nothing new is loaded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outData  <= '0;
      r_outLast  <= 1'b0;
      r_outSel   <= '0;
      r_outValid <= 1'b0;
    end else if (w_xfer) begin
      r_outData  <= w_grantData;
      r_outLast  <= w_grantLast;
      r_outSel   <= w_grant;
      r_outValid <= 1'b1;
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  // Pointer register; stays put during stalls because w_xfer is then 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptrNext;
    end
  end

  assign out_data  = r_outData;
  assign out_last  = r_outLast;
  assign out_sel   = r_outSel;
  assign out_valid = r_outValid;

endmodule

// File: tb/tb_rr_stream_mux.sv
// -----------------------------------------------------------------------------
// tb_rr_stream_mux
// Self-checking bench for rr_stream_mux (N = 4, WIDTH = 8). Each scenario task
// queues the beats it expects and pops/compares them as the output drains.
// Build with RR_STREAM_MUX_PKT_LOCK_EN defined to check packet locking.
// -----------------------------------------------------------------------------
module tb_rr_stream_mux;

  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SELW  = 2;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [1:0] sel;
  } beat_t;

  logic               clk;
  logic               rst_n;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_last;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_last;
  logic [SELW-1:0]    out_sel;
  logic               out_valid;
  logic               out_ready;

  int    compared;
  int    mismatched;
  beat_t expQ[$];
  beat_t expBeat;

  rr_stream_mux #(.WIDTH(WIDTH), .N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_last (out_last),
    .out_sel  (out_sel),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // 10 time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic beat_t mkBeat(input logic [7:0] d, input logic l, input logic [1:0] s);
    beat_t b;
    b.data = d;
    b.last = l;
    b.sel  = s;
    return b;
  endfunction

  // Advance to just after the next rising edge, where inputs are driven and
  // outputs are sampled.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    in_last   = 4'b0000;
    in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    out_ready = 1'b1;
    stepCycle();
    stepCycle();
    compared++;
    if (in_ready !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL ready_in_reset: got %b want 0000", in_ready);
    end
    in_valid = 4'b0000;
    rst_n    = 1'b1;
    for (int c = 0; c < 5; c++) begin
      stepCycle();
      compared++;
      if ({out_valid, out_last, out_data, out_sel, in_ready} !== 16'h0000) begin
        mismatched++;
        $display("[TB] FAIL idle_after_reset[%0d]: got valid=%b data=%h sel=%0d ready=%b want all 0",
                 c, out_valid, out_data, out_sel, in_ready);
      end
    end
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 8; i++) begin
      expQ.push_back(mkBeat(8'(8'h11 * ((i % 4) + 1)), 1'b1, 2'(i % 4)));
    end
    in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    in_last   = 4'b1111;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      stepCycle();
      if (c < 8) begin
        compared++;
        if (out_valid !== 1'b1) begin
          mismatched++;
          $display("[TB] FAIL rr_throughput[%0d]: out_valid=%b want 1", c, out_valid);
        end
      end
      if (out_valid && out_ready) begin
        compared++;
        if (expQ.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL rr_beat: got data=%h sel=%0d, none expected", out_data, out_sel);
        end else begin
          expBeat = expQ.pop_front();
          if ({out_data, out_last, out_sel} !== expBeat) begin
            mismatched++;
            $display("[TB] FAIL rr_beat: got data=%h last=%b sel=%0d want data=%h last=%b sel=%0d",
                     out_data, out_last, out_sel, expBeat.data, expBeat.last, expBeat.sel);
          end
        end
      end
      if (c == 7) in_valid = 4'b0000;
    end
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL rr_drain: %0d beats missing, want 0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic test_stall();
    expQ.push_back(mkBeat(8'hA5, 1'b1, 2'd2));
    expQ.push_back(mkBeat(8'h5A, 1'b1, 2'd2));
    in_data   = {8'h00, 8'hA5, 8'h00, 8'h00};
    in_last   = 4'b1111;
    in_valid  = 4'b0100;
    out_ready = 1'b0;
    #1;
    compared++;
    if (in_ready !== 4'b0100) begin
      mismatched++;
      $display("[TB] FAIL stall_first_ready: got %b want 0100", in_ready);
    end
    stepCycle();
    in_data = {8'h00, 8'h5A, 8'h00, 8'h00};
    for (int c = 0; c < 3; c++) begin
      #1;
      compared++;
      if ({out_valid, out_data, out_sel, in_ready} !== {1'b1, 8'hA5, 2'd2, 4'b0000}) begin
        mismatched++;
        $display("[TB] FAIL stall_hold[%0d]: got valid=%b data=%h sel=%0d ready=%b want 1 a5 2 0000",
                 c, out_valid, out_data, out_sel, in_ready);
      end
      stepCycle();
    end
    out_ready = 1'b1;
    #1;
    compared++;
    if (in_ready !== 4'b0100) begin
      mismatched++;
      $display("[TB] FAIL stall_release_ready: got %b want 0100", in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      if (out_valid && out_ready) begin
        compared++;
        if (expQ.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL stall_beat: got data=%h sel=%0d, none expected", out_data, out_sel);
        end else begin
          expBeat = expQ.pop_front();
          if ({out_data, out_last, out_sel} !== expBeat) begin
            mismatched++;
            $display("[TB] FAIL stall_beat: got data=%h last=%b sel=%0d want data=%h last=%b sel=%0d",
                     out_data, out_last, out_sel, expBeat.data, expBeat.last, expBeat.sel);
          end
        end
      end
      stepCycle();
      if (c == 0) in_valid = 4'b0000;
    end
    compared++;
    if (out_valid !== 1'b0 || expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL stall_drain: out_valid=%b pending=%0d want 0 and 0", out_valid, expQ.size());
      expQ.delete();
    end
  endtask

  task automatic test_wraparound();
    expQ.push_back(mkBeat(8'hB1, 1'b1, 2'd1));
    expQ.push_back(mkBeat(8'hD3, 1'b1, 2'd3));
    expQ.push_back(mkBeat(8'hC1, 1'b1, 2'd1));
    in_data   = {8'hD3, 8'h00, 8'hB1, 8'h00};
    in_last   = 4'b1111;
    in_valid  = 4'b0010;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      stepCycle();
      if (c == 0) begin
        in_valid = 4'b1010;
        in_data  = {8'hD3, 8'h00, 8'hC1, 8'h00};
        #1;
        compared++;
        if (in_ready !== 4'b1000) begin
          mismatched++;
          $display("[TB] FAIL wrap_ready_ptr2: got %b want 1000", in_ready);
        end
      end
      if (c == 2) in_valid = 4'b0000;
      if (out_valid && out_ready) begin
        compared++;
        if (expQ.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL wrap_beat: got data=%h sel=%0d, none expected", out_data, out_sel);
        end else begin
          expBeat = expQ.pop_front();
          if ({out_data, out_last, out_sel} !== expBeat) begin
            mismatched++;
            $display("[TB] FAIL wrap_beat: got data=%h last=%b sel=%0d want data=%h last=%b sel=%0d",
                     out_data, out_last, out_sel, expBeat.data, expBeat.last, expBeat.sel);
          end
        end
      end
    end
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL wrap_drain: %0d beats missing, want 0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic test_reset_mid();
    in_data   = {8'h00, 8'hE2, 8'h00, 8'h00};
    in_last   = 4'b1111;
    in_valid  = 4'b0100;
    out_ready = 1'b0;
    stepCycle();
    compared++;
    if ({out_valid, out_data} !== {1'b1, 8'hE2}) begin
      mismatched++;
      $display("[TB] FAIL midrst_loaded: got valid=%b data=%h want 1 e2", out_valid, out_data);
    end
    in_valid = 4'b0000;
    rst_n    = 1'b0;
    stepCycle();
    compared++;
    if ({out_valid, out_data, out_sel, in_ready} !== 15'h0000) begin
      mismatched++;
      $display("[TB] FAIL midrst_cleared: got valid=%b data=%h sel=%0d ready=%b want all 0",
               out_valid, out_data, out_sel, in_ready);
    end
    rst_n     = 1'b1;
    in_valid  = 4'b1010;
    in_data   = {8'h93, 8'h00, 8'h91, 8'h00};
    out_ready = 1'b1;
    expQ.push_back(mkBeat(8'h91, 1'b1, 2'd1));
    expQ.push_back(mkBeat(8'h93, 1'b1, 2'd3));
    #1;
    compared++;
    if (in_ready !== 4'b0010) begin
      mismatched++;
      $display("[TB] FAIL midrst_ptr0: got ready=%b want 0010", in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      stepCycle();
      if (c == 1) in_valid = 4'b0000;
      if (out_valid && out_ready) begin
        compared++;
        if (expQ.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL midrst_beat: got data=%h sel=%0d, none expected", out_data, out_sel);
        end else begin
          expBeat = expQ.pop_front();
          if ({out_data, out_last, out_sel} !== expBeat) begin
            mismatched++;
            $display("[TB] FAIL midrst_beat: got data=%h last=%b sel=%0d want data=%h last=%b sel=%0d",
                     out_data, out_last, out_sel, expBeat.data, expBeat.last, expBeat.sel);
          end
        end
      end
    end
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL midrst_drain: %0d beats missing, want 0", expQ.size());
      expQ.delete();
    end
  endtask

  // Channel 0 sends a packet while channel 1 is always valid. With the lock
  // build the packet goes out unbroken; otherwise the channels alternate.
  task automatic test_packet();
    logic [3:0] wantReady;
    int         beats;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    beats = 4;
    expQ.push_back(mkBeat(8'h01, 1'b0, 2'd0));
    expQ.push_back(mkBeat(8'h02, 1'b0, 2'd0));
    expQ.push_back(mkBeat(8'h03, 1'b1, 2'd0));
    expQ.push_back(mkBeat(8'hF1, 1'b1, 2'd1));
`else
    beats = 2;
    expQ.push_back(mkBeat(8'h01, 1'b0, 2'd0));
    expQ.push_back(mkBeat(8'hF1, 1'b1, 2'd1));
`endif
    in_data   = {8'h00, 8'h00, 8'hF1, 8'h01};
    in_last   = 4'b0010;
    in_valid  = 4'b0011;
    out_ready = 1'b1;
    #1;
    compared++;
    if (in_ready !== 4'b0001) begin
      mismatched++;
      $display("[TB] FAIL pkt_first_ready: got %b want 0001", in_ready);
    end
    for (int c = 0; c < beats + 1; c++) begin
      stepCycle();
      if (out_valid && out_ready) begin
        compared++;
        if (expQ.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL pkt_beat: got data=%h sel=%0d, none expected", out_data, out_sel);
        end else begin
          expBeat = expQ.pop_front();
          if ({out_data, out_last, out_sel} !== expBeat) begin
            mismatched++;
            $display("[TB] FAIL pkt_beat: got data=%h last=%b sel=%0d want data=%h last=%b sel=%0d",
                     out_data, out_last, out_sel, expBeat.data, expBeat.last, expBeat.sel);
          end
        end
      end
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
      if (c == 0) begin
        in_data = {8'h00, 8'h00, 8'hF1, 8'h02};
        wantReady = 4'b0001;
      end else if (c == 1) begin
        in_data = {8'h00, 8'h00, 8'hF1, 8'h03};
        in_last = 4'b0011;
        wantReady = 4'b0001;
      end else if (c == 2) begin
        in_valid = 4'b0010;
        wantReady = 4'b0010;
      end else begin
        in_valid = 4'b0000;
        wantReady = 4'b0000;
      end
`else
      if (c == 0) begin
        wantReady = 4'b0010;
      end else begin
        in_valid = 4'b0000;
        wantReady = 4'b0000;
      end
`endif
      #1;
      compared++;
      if (in_ready !== wantReady) begin
        mismatched++;
        $display("[TB] FAIL pkt_ready[%0d]: got %b want %b", c, in_ready, wantReady);
      end
    end
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL pkt_drain: %0d beats missing, want 0", expQ.size());
      expQ.delete();
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    in_data    = '0;
    in_valid   = '0;
    in_last    = '0;
    out_ready  = 1'b0;
    test_reset();
    test_round_robin();
    test_stall();
    test_wraparound();
    test_reset_mid();
    test_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
